// File: rtl/pin_input_filter_pkg.sv
// Shared pin counts, vector types and pin indices for the pad input filter.
package pin_input_filter_pkg;

   localparam int unsigned IN_PIN_NUM        = 8;
   localparam int unsigned INOUT_PIN_NUM     = 68;
   localparam int unsigned PIN_FILT_NUM      = IN_PIN_NUM + INOUT_PIN_NUM;
   localparam int unsigned PIN_SYNC_STAGES   = 2;
   localparam int unsigned PIN_FILTER_CYCLES = 4;

   typedef logic [IN_PIN_NUM-1:0]    sonata_in_pins_t;
   typedef logic [INOUT_PIN_NUM-1:0] sonata_inout_pins_t;
   typedef logic [PIN_FILT_NUM-1:0]  sonata_filt_pins_t;

   // Input-only pad indices within in_pins.
   typedef enum int unsigned {
      IN_PIN_SER0_RX = 0,
      IN_PIN_SER1_RX = 1,
      IN_PIN_SER2_RX = 2,
      IN_PIN_RS232_RX = 3,
      IN_PIN_RS485_RX = 4,
      IN_PIN_SPI0_CIPO = 5,
      IN_PIN_SPI1_CIPO = 6,
      IN_PIN_USRSW = 7
   } in_pin_e;

   // Leading inout pad indices within inout_pins.
   typedef enum int unsigned {
      INOUT_PIN_SCL0 = 0,
      INOUT_PIN_SDA0 = 1,
      INOUT_PIN_SCL1 = 2,
      INOUT_PIN_SDA1 = 3
   } inout_pin_e;

   // Width of a stability counter that must reach cycles-1 without wrapping.
   function automatic int unsigned filt_cnt_width(input int unsigned cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/pin_input_filter_bit.sv
// One pad: reset-able synchroniser, optional stability filter and edge pulses.
module pin_filter_bit
   import pin_input_filter_pkg::*;
#(
   parameter int unsigned SyncStages   = PIN_SYNC_STAGES,
   parameter int unsigned FilterCycles = PIN_FILTER_CYCLES,
   parameter logic        ResetVal     = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pin_i,
   input  logic filt_en_i,
   output logic pin_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int unsigned   CntW    = filt_cnt_width(FilterCycles);
   localparam logic [CntW-1:0] CntLast = CntW'(FilterCycles - 1);

   logic [SyncStages-1:0] sync_q;
   logic                  y;
   logic                  s_q, s_d;
   logic                  s_prev_q;
   logic [CntW-1:0]       c_q, c_d;

   assign y = sync_q[SyncStages-1];

   // Synchroniser chain; every stage resets so no stale pad value survives reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= {SyncStages{ResetVal}};
      end else begin
         sync_q <= {sync_q[SyncStages-2:0], pin_i};
      end
   end

   // Next stable value and counter: accept y only after it differs for FilterCycles edges.
   always_comb begin
      s_d = s_q;
      c_d = '0;
      if (!filt_en_i) begin
         s_d = y;
      end else if (y != s_q) begin
         if (c_q == CntLast) begin
            s_d = y;
         end else begin
            c_d = c_q + CntW'(1);
         end
      end
   end

   // Stable, previous-stable and counter registers; reset loads both s and s_prev so no edge fires.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s_q      <= ResetVal;
         s_prev_q <= ResetVal;
         c_q      <= '0;
      end else begin
         s_q      <= s_d;
         s_prev_q <= s_q;
         c_q      <= c_d;
      end
   end

   assign pin_o  = s_q;
   assign rise_o = s_q & ~s_prev_q;
   assign fall_o = ~s_q & s_prev_q;

endmodule

// File: rtl/pin_input_filter.sv
// Synchronises and glitch-filters every in and inout pad ahead of the pinmux.
module pin_input_filter
   import pin_input_filter_pkg::*;
#(
   parameter int unsigned        SyncStages    = PIN_SYNC_STAGES,
   parameter int unsigned        FilterCycles  = PIN_FILTER_CYCLES,
   parameter sonata_in_pins_t    InResetVal    = '1,
   parameter sonata_inout_pins_t InoutResetVal = '1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  sonata_in_pins_t    in_pins_i,
   input  sonata_inout_pins_t inout_pins_i,
   input  sonata_filt_pins_t  filt_en_i,
   output sonata_in_pins_t    in_pins_o,
   output sonata_inout_pins_t inout_pins_o,
   output sonata_filt_pins_t  rise_o,
   output sonata_filt_pins_t  fall_o
);

   // In pins occupy the low bits, inout pins the bits above.
   localparam sonata_filt_pins_t ResetVals = {InoutResetVal, InResetVal};

   sonata_filt_pins_t raw;
   sonata_filt_pins_t filt;

   assign raw = {inout_pins_i, in_pins_i};

   for (genvar p = 0; p < PIN_FILT_NUM; p++) begin : g_pin
      pin_filter_bit #(
         .SyncStages  (SyncStages),
         .FilterCycles(FilterCycles),
         .ResetVal    (ResetVals[p])
      ) u_bit (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .pin_i    (raw[p]),
         .filt_en_i(filt_en_i[p]),
         .pin_o    (filt[p]),
         .rise_o   (rise_o[p]),
         .fall_o   (fall_o[p])
      );
   end

   assign in_pins_o    = filt[IN_PIN_NUM-1:0];
   assign inout_pins_o = filt[PIN_FILT_NUM-1:IN_PIN_NUM];

endmodule

// File: doc/pin_input_filter.md
Name: pin_input_filter

Overview:
- Sits directly upstream of the pinmux input path, between the top-level pads and the pinmux.
- Synchronises every Sonata input pin and every inout-pin input value into the system clock domain.
- Per pin, applies an optional glitch filter: a consecutive-cycle stability counter.
- Produces clean pin values plus one-cycle rise and fall pulses. GPIO and peripheral logic consume these without their own synchronisers.

Parameters:
- SyncStages, 2, synchroniser flop depth; legal range 2..4.
- FilterCycles, 4, consecutive cycles a new level must persist before it is accepted; must be ≥1.
- InResetVal, '1, reset level of the IN_PIN_NUM in-pin path (UART RX idles high).
- InoutResetVal, '1, reset level of the INOUT_PIN_NUM inout-pin path (I2C idles high).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, synchronous to clk_i and active-high.
- in_pins_i  in  IN_PIN_NUM  raw asynchronous input pad values.
- inout_pins_i  in  INOUT_PIN_NUM  raw asynchronous inout pad input values.
- filt_en_i  in  PIN_FILT_NUM  per-pin filter enable; bits [IN_PIN_NUM-1:0] are in pins, bits above are inout pins. Quasi-static, already synchronous.
- in_pins_o  out  IN_PIN_NUM  filtered in-pin values.
- inout_pins_o  out  INOUT_PIN_NUM  filtered inout-pin values.
- rise_o  out  PIN_FILT_NUM  one-cycle pulse when the filtered value goes 0→1.
- fall_o  out  PIN_FILT_NUM  one-cycle pulse when the filtered value goes 1→0.

Interface decision: single clock clk_i; reset rst_i is synchronous and active-high.

Behaviour:
- Pin indexing: pin p in [0, PIN_FILT_NUM); p < IN_PIN_NUM maps to in_pins, else to inout_pins[p-IN_PIN_NUM]. All pins are independent and identical.
- Reset (rst_i=1 at a clk_i edge):
  - sync flops, stable register s and previous register s_prev all load the pin's reset value.
  - Counter c loads 0.
  - rise_o and fall_o read 0, and no edge pulse fires on reset release.
- Reset asserted mid-count aborts the count; a pending change is discarded.
- Synchroniser: a chain of SyncStages flops. Output y is the last stage. No reset-free flops.
- Filter disabled (filt_en_i[p]=0):
  - s <= y every cycle; c <= 0.
  - Latency from pad to output is SyncStages+1 cycles.
- Filter enabled (filt_en_i[p]=1):
  - If y == s: c <= 0.
  - Else if c == FilterCycles-1: s <= y, c <= 0.
  - Else: c <= c+1.
  - Result: s changes exactly FilterCycles cycles after y first differs, provided y holds the new level throughout. Any return of y to s resets c.
  - FilterCycles=1 is identical to disabled.
- Counter width is $clog2(FilterCycles+1). c never exceeds FilterCycles-1, so no wrap is possible.
- Enable toggled mid-count:
  - 1→0: c clears and s tracks y on the next edge.
  - 0→1: counting starts from c=0.
- Outputs:
  - in_pins_o / inout_pins_o = s (registered).
  - s_prev <= s every cycle.
  - rise_o = s & ~s_prev; fall_o = ~s & s_prev. These are combinational from registers and high in the first cycle s shows its new value.
- Rise and fall are mutually exclusive per pin. Simultaneous events on different pins are independent.

Decomposition:
- Add to sonata_pkg:
  - PIN_FILT_NUM = IN_PIN_NUM + INOUT_PIN_NUM.
  - PIN_FILTER_CYCLES default constant.
  - typedef sonata_filt_pins_t logic [PIN_FILT_NUM-1:0].
- Top reuses sonata_in_pins_t and sonata_inout_pins_t for the split ports.
- One natural sub-module: pin_filter_bit. It is single-bit sync + counter + s/s_prev + edge, with parameters SyncStages, FilterCycles and a 1-bit ResetVal.
- The top instantiates pin_filter_bit PIN_FILT_NUM times in a generate loop, then concatenates and splits the vectors.

Test Plan:
- Reset values: hold rst_i 3 cycles with in_pins_i=0, then release. Required: in_pins_o=8'hFF and inout_pins_o all 1 until the synchronised 0 propagates. No rise_o pulse at release; fall_o pulses exactly once per pin, SyncStages+1 (filter off) or SyncStages+FilterCycles (filter on) cycles after release.
- Disabled latency: filt_en_i=0, drive in_pins_i[IN_PIN_SER0_RX] 1→0 at cycle 0. Required: in_pins_o[0]=0 at cycle 3 (SyncStages=2) and fall_o[0]=1 for that single cycle.
- Glitch rejection: FilterCycles=4, filter on, inout pin INOUT_PIN_SDA0 low for 3 cycles then high. Required: inout_pins_o[1] stays 1 and no fall_o[IN_PIN_NUM+1] pulse.
- Accepted change: same pin low for 4+ cycles. Required: output falls exactly 4 cycles after y first goes low (cycle 6 from pad); fall_o pulses once; later rise after 4 more stable high cycles.
- Mid-count events: with c=2, deassert filt_en_i, then separately assert rst_i. Required: disable → output follows y next cycle; reset → output returns to reset value, c=0, no edge pulse.
- Independence: toggle all 76 pins with alternating enables. Required: each pin's latency matches its own enable; no cross-pin interaction.
